div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//   Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU. Sits between operand read
//   and register-file write: consumes rs1/rs2 operand data plus destination address,
//   runs for DATA_WIDTH cycles and issues a single-cycle write to the register file.
//   Stalls issue via busy_o; the pipeline holds further M-ext ops while busy.
// PARAMETERS
//   DATA_WIDTH     32                   operand/result width
//   ADDR_WIDTH_RF  5                    register address width
//   CNT_WIDTH      $clog2(DATA_WIDTH)+1 iteration counter width
// PORTS
//   clk_i           in   1              clock, rising edge
//   rst_i           in   1              asynchronous reset, active-high
//   start_i         in   1              issue request; sampled only in IDLE
//   op_i            in   2              funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_data_i      in   DATA_WIDTH     dividend
//   rs2_data_i      in   DATA_WIDTH     divisor
//   rd_addr_i       in   ADDR_WIDTH_RF  destination register
//   busy_o          out  1              high whenever state != IDLE
//   done_o          out  1              one-cycle completion pulse
//   reg_write_en_o  out  1              register-file write enable (done_o && rd != 0)
//   rd_addr_o       out  ADDR_WIDTH_RF  destination register of completed op
//   rd_data_o       out  DATA_WIDTH     result of completed op
// BEHAVIOUR
//   Reset (rst_i high, async): state IDLE, counter 0, every output 0. Reset mid-op
//   discards the op; no write is issued.
//   FSM: IDLE -> CALC -> DONE -> IDLE, or IDLE -> DONE (fast path).
//   - IDLE: at a clock edge with start_i=1, latch op, rd_addr, operands. Special case
//     -> DONE; otherwise -> CALC with counter 0. start_i=0 keeps IDLE.
//   - CALC: one restoring step per edge on operand magnitudes (shift remainder left,
//     bring in next dividend MSB, subtract divisor if no borrow, set quotient bit).
//     After DATA_WIDTH steps -> DONE. start_i ignored.
//   - DONE: done_o=1 for exactly this cycle; next edge -> IDLE. start_i ignored.
//   Latency: normal op done_o is high in the cycle after edge E0+DATA_WIDTH (E0 =
//   accepting edge); fast path done_o is high in the cycle after E0. Next start is
//   accepted at the edge that leaves DONE is NOT allowed: earliest accept is the
//   first edge seen in IDLE (one idle cycle minimum between ops).
//   Signed (op_i[0]=0): operands take absolute value before iterating; quotient
//   negated if operand signs differ; remainder takes dividend's sign. Unsigned: raw.
//   Result select: op_i[1]=0 quotient, op_i[1]=1 remainder.
//   Fast path (special cases, RISC-V defined, no trap):
//   - divisor==0: quotient = all ones, remainder = dividend (signed and unsigned).
//   - signed overflow (dividend = 0x8000_0000, divisor = all ones): quotient =
//     dividend, remainder = 0.
//   Outputs: rd_addr_o/rd_data_o registered, updated on entry to DONE, held until
//   next completion. reg_write_en_o = done_o && (rd_addr_o != 0); done_o still
//   pulses for rd = x0 so issue logic can release.
//   Operands are captured at accept; later changes on *_data_i have no effect.
// TESTING
//   DIVU 100/7, rd=5 -> after 32 CALC cycles one pulse: rd_addr_o=5, rd_data_o=14,
//     reg_write_en_o=1; busy_o high 33 cycles.
//   REM -7/2 (0xFFFFFFF9, 2) -> rd_data_o=0xFFFFFFFF (-1); DIV same -> 0xFFFFFFFD (-3).
//   DIV 0x12345678/0 -> fast path, next cycle rd_data_o=0xFFFFFFFF; REMU x/0 ->
//     0x12345678; busy_o high for 1 cycle only.
//   DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; both via fast path.
//   rd=0 DIV 9/3 -> done_o pulses, reg_write_en_o stays 0; start_i held high while
//     busy plus operand changes -> ignored, result still 3, single done_o.
//   Assert rst_i at CALC step 10 -> outputs 0 immediately, no done_o; next DIVU 9/3
//     completes normally with 3.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle; divide-by-zero and signed overflow take a one-cycle fast path.
module div_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH_RF = 5,
  parameter int CNT_WIDTH     = $clog2(DATA_WIDTH) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [1:0]               op_i,
  input  logic [DATA_WIDTH-1:0]    rs1_data_i,
  input  logic [DATA_WIDTH-1:0]    rs2_data_i,
  input  logic [ADDR_WIDTH_RF-1:0] rd_addr_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     reg_write_en_o,
  output logic [ADDR_WIDTH_RF-1:0] rd_addr_o,
  output logic [DATA_WIDTH-1:0]    rd_data_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0]     cnt;
  logic [ADDR_WIDTH_RF-1:0] rd_q;
  logic                     sel_rem_q;
  logic                     neg_quo_q;
  logic                     neg_rem_q;
  logic [DATA_WIDTH-1:0]    quo_q;
  logic [DATA_WIDTH-1:0]    rem_q;
  logic [DATA_WIDTH-1:0]    dvs_q;

  logic                     accept;
  logic                     is_signed;
  logic                     div_zero;
  logic                     sgn_ovf;
  logic                     special;
  logic [DATA_WIDTH-1:0]    fast_res;
  logic                     last;
  logic [DATA_WIDTH:0]      rem_sh;
  logic [DATA_WIDTH:0]      diff;
  logic                     take;
  logic [DATA_WIDTH-1:0]    rem_nxt;
  logic [DATA_WIDTH-1:0]    quo_nxt;
  logic [DATA_WIDTH-1:0]    calc_res;

  function automatic logic [DATA_WIDTH-1:0] abs_mag(input logic signed [DATA_WIDTH-1:0] v,
                                                    input logic en);
    logic signed [DATA_WIDTH-1:0] n;
    n = -v;
    return (en && v[DATA_WIDTH-1]) ? DATA_WIDTH'(n) : DATA_WIDTH'(v);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] negate_if(input logic signed [DATA_WIDTH-1:0] v,
                                                      input logic en);
    logic signed [DATA_WIDTH-1:0] n;
    n = -v;
    return en ? DATA_WIDTH'(n) : DATA_WIDTH'(v);
  endfunction

  assign accept    = (state == IDLE) && start_i;
  assign is_signed = ~op_i[0];
  assign div_zero  = (rs2_data_i == '0);
  assign sgn_ovf   = is_signed && (rs1_data_i == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                     && (rs2_data_i == '1);
  assign special   = div_zero || sgn_ovf;

  always_comb begin
    fast_res = '0;
    if (op_i[1]) fast_res = div_zero ? rs1_data_i : '0;
    else         fast_res = div_zero ? '1 : rs1_data_i;
  end

  // Restoring step: shift in next dividend bit, subtract divisor if it fits.
  assign rem_sh  = {rem_q, quo_q[DATA_WIDTH-1]};
  assign diff    = rem_sh - {1'b0, dvs_q};
  assign take    = ~diff[DATA_WIDTH];
  assign rem_nxt = take ? diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
  assign quo_nxt = {quo_q[DATA_WIDTH-2:0], take};
  assign last    = (cnt == CNT_WIDTH'(DATA_WIDTH - 1));

  assign calc_res = sel_rem_q ? negate_if(rem_nxt, neg_rem_q) : negate_if(quo_nxt, neg_quo_q);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = special ? DONE : CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
        if (special) begin
          rd_addr_o <= rd_addr_i;
          rd_data_o <= fast_res;
        end
      end else if (state == CALC) begin
        if (last) begin
          rd_addr_o <= rd_q;
          rd_data_o <= calc_res;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Operand capture at accept, then iterate on magnitudes.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      rd_q      <= rd_addr_i;
      sel_rem_q <= op_i[1];
      neg_quo_q <= is_signed && (rs1_data_i[DATA_WIDTH-1] ^ rs2_data_i[DATA_WIDTH-1]);
      neg_rem_q <= is_signed && rs1_data_i[DATA_WIDTH-1];
      quo_q     <= abs_mag(rs1_data_i, is_signed);
      dvs_q     <= abs_mag(rs2_data_i, is_signed);
      rem_q     <= '0;
    end else if (state == CALC) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

  assign busy_o         = (state != IDLE);
  assign done_o         = (state == DONE);
  assign reg_write_en_o = done_o && (rd_addr_o != '0);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: RV32M divide/remainder vectors,
// fast-path special cases, x0 destination, ignored start while busy, mid-op reset.
module tb_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o;
  logic        done_o;
  logic        reg_write_en_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  div_unit #(.DATA_WIDTH(32), .ADDR_WIDTH_RF(5)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .op_i           (op_i),
    .rs1_data_i     (rs1_data_i),
    .rs2_data_i     (rs2_data_i),
    .rd_addr_i      (rd_addr_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .reg_write_en_o (reg_write_en_o),
    .rd_addr_o      (rd_addr_o),
    .rd_data_o      (rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int exp_lat, input bit hold);
    int n;
    int busy_n;
    int done_n;
    @(negedge clk_i);
    op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd; start_i = 1'b1;
    @(posedge clk_i); #1;
    if (hold) begin
      op_i = ~op; rs1_data_i = ~a; rs2_data_i = 32'd1; rd_addr_i = 5'd31;
    end else begin
      start_i = 1'b0;
    end
    n = 0; busy_n = int'(busy_o); done_n = 0;
    while (!done_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
      busy_n += int'(busy_o);
      if (hold) rs1_data_i = rs1_data_i + 32'd1;
    end
    done_n = int'(done_o);
    start_i = 1'b0;
    check({name, " latency"}, 32'(n), 32'(exp_lat));
    check({name, " busy cycles"}, 32'(busy_n), 32'(exp_lat + 1));
    check({name, " rd_data"}, rd_data_o, exp);
    check({name, " rd_addr"}, 32'(rd_addr_o), 32'(rd));
    check({name, " write_en"}, 32'(reg_write_en_o), 32'(rd != 5'd0));
    @(posedge clk_i); #1;
    done_n += int'(done_o);
    check({name, " done pulses"}, 32'(done_n), 32'd1);
    check({name, " busy after"}, 32'(busy_o), 32'd0);
    check({name, " data held"}, rd_data_o, exp);
  endtask

  initial begin
    int seen;
    rst_i = 1'b1; start_i = 1'b0; op_i = 2'b00;
    rs1_data_i = '0; rs2_data_i = '0; rd_addr_i = '0;
    #3;
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset we", 32'(reg_write_en_o), 32'd0);
    check("reset rd_addr", 32'(rd_addr_o), 32'd0);
    check("reset rd_data", rd_data_o, 32'd0);
    @(negedge clk_i); rst_i = 1'b0;

    run_op("divu 100/7",   OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         32, 1'b0);
    run_op("rem -7/2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  32, 1'b0);
    run_op("div -7/2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFD,  32, 1'b0);
    run_op("div -100/7",   OP_DIV,  32'hFFFF_FF9C,  32'd7,          5'd8,  32'hFFFF_FFF2,  32, 1'b0);
    run_op("rem 100/-7",   OP_REM,  32'd100,        32'hFFFF_FFF9,  5'd9,  32'd2,          32, 1'b0);
    run_op("remu big/2",   OP_REMU, 32'hFFFF_FFF9,  32'd2,          5'd10, 32'd1,          32, 1'b0);
    run_op("divu max/1",   OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd11, 32'hFFFF_FFFF,  32, 1'b0);
    run_op("divu min/m1",  OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'd0,          32, 1'b0);
    run_op("div by 0",     OP_DIV,  32'h1234_5678,  32'd0,          5'd7,  32'hFFFF_FFFF,  0,  1'b0);
    run_op("remu by 0",    OP_REMU, 32'h1234_5678,  32'd0,          5'd7,  32'h1234_5678,  0,  1'b0);
    run_op("div ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h8000_0000,  0,  1'b0);
    run_op("rem ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'd0,          0,  1'b0);
    run_op("x0 div 9/3",   OP_DIV,  32'd9,          32'd3,          5'd0,  32'd3,          32, 1'b1);
    run_op("pre-reset op", OP_DIVU, 32'd50,         32'd5,          5'd4,  32'd10,         32, 1'b0);

    // Mid-operation reset discards the op.
    @(negedge clk_i);
    op_i = OP_DIVU; rs1_data_i = 32'd1000; rs2_data_i = 32'd3; rd_addr_i = 5'd2; start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    check("midrst busy", 32'(busy_o), 32'd0);
    check("midrst done", 32'(done_o), 32'd0);
    check("midrst we", 32'(reg_write_en_o), 32'd0);
    check("midrst rd_addr", 32'(rd_addr_o), 32'd0);
    check("midrst rd_data", rd_data_o, 32'd0);
    @(negedge clk_i); rst_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      seen += int'(done_o) + int'(busy_o);
    end
    check("midrst no activity", 32'(seen), 32'd0);
    run_op("divu 9/3 post", OP_DIVU, 32'd9, 32'd3, 5'd3, 32'd3, 32, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
